icache_sa: RTL

- Parametrised instruction cache between the fetch stage and instruction memory; successor to the fixed 8-line direct-mapped cache.
- Configurable sets, line size and associativity (1 or 2 ways, LRU replacement).
- Refill uses a req/valid handshake with memory instead of a fixed wait count.
- Adds a multi-cycle flush sequencer and a saturating miss counter.

---
 rtl/icache_sa.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/icache_sa.sv
`default_nettype none
// ============================================================================
// Module   : icache_sa
// Purpose  : Set-associative instruction cache (1 or 2 ways, LRU) between
//            the fetch stage and instruction memory. Misses refill a whole
//            line through a req/valid handshake. A flush walks every set
//            over SETS cycles. A saturating counter tracks misses.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   cpu_req    in   fetch request valid
//   cpu_addr   in   fetch word address
//   hit        out  requested word valid this cycle (combinational)
//   ins        out  fetched instruction, 0 when hit = 0
//   flush      in   one-cycle pulse, invalidates all lines
//   busy       out  sequencer is refilling or flushing
//   mem_req    out  line refill request
//   mem_addr   out  line-aligned refill word address
//   mem_valid  in   mem_line carries the requested line this cycle
//   mem_line   in   refill data, word k at bits [32k+31:32k]
//   miss_count out  number of misses, saturating at 0xFFFF
// ============================================================================
module icache_sa #(
    parameter int ADDR_W     = 30,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 8,
    parameter int WAYS       = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cpu_req,
    input  logic [ADDR_W-1:0]         cpu_addr,
    output logic                      hit,
    output logic [31:0]               ins,
    input  logic                      flush,
    output logic                      busy,
    output logic                      mem_req,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic                      mem_valid,
    input  logic [32*LINE_WORDS-1:0]  mem_line,
    output logic [15:0]               miss_count
);

    localparam int c_OFF = $clog2(LINE_WORDS);
    localparam int c_IDX = $clog2(SETS);
    localparam int c_TAG = ADDR_W - c_IDX - c_OFF;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_REFILL = 2'd1;
    localparam logic [1:0] c_FLUSH  = 2'd2;

    logic [1:0]                r_state;
    logic [c_IDX-1:0]          r_fcnt;
    logic                      r_flush_pend;
    logic [WAYS-1:0]           r_valid [SETS];
    logic [c_TAG-1:0]          r_tag   [WAYS][SETS];
    logic [32*LINE_WORDS-1:0]  r_data  [WAYS][SETS];
    // Per set: the way to evict next when both ways are valid.
    logic [SETS-1:0]           r_lru;
    logic                      r_mem_req;
    logic [ADDR_W-1:0]         r_mem_addr;
    logic [15:0]               r_miss_count;

    logic [c_OFF-1:0]          w_off;
    logic [c_IDX-1:0]          w_idx;
    logic [c_TAG-1:0]          w_tag;
    logic [c_IDX-1:0]          w_fidx;
    logic [c_TAG-1:0]          w_ftag;
    logic [WAYS-1:0]           w_way_hit;
    logic [WAYS-1:0]           w_victim_oh;
    logic                      w_hit;
    logic                      w_fill;
    logic [31:0]               w_rd;

    assign w_off  = cpu_addr[c_OFF-1:0];
    assign w_idx  = cpu_addr[c_OFF +: c_IDX];
    assign w_tag  = cpu_addr[ADDR_W-1 -: c_TAG];
    // During a refill the set/tag come from the latched line address, so
    // cpu_addr is free to change.
    assign w_fidx = r_mem_addr[c_OFF +: c_IDX];
    assign w_ftag = r_mem_addr[ADDR_W-1 -: c_TAG];

    generate
        for (genvar g = 0; g < WAYS; g++) begin : g_way_cmp
            assign w_way_hit[g] = r_valid[w_idx][g] && (r_tag[g][w_idx] == w_tag);
        end
    endgenerate

    generate
        if (WAYS == 1) begin : g_victim_dm
            assign w_victim_oh = 1'b1;
        end else begin : g_victim_2way
            // First invalid way wins; otherwise the LRU pointer decides.
            assign w_victim_oh = !r_valid[w_fidx][0] ? 2'b01 :
                                 !r_valid[w_fidx][1] ? 2'b10 :
                                 (r_lru[w_fidx] ? 2'b10 : 2'b01);
        end
    endgenerate

    assign w_hit  = (r_state == c_IDLE) && cpu_req && (|w_way_hit);
    assign w_fill = (r_state == c_REFILL) && mem_valid;

    // At most one way matches, so OR-ing the gated words selects it.
    always_comb begin
        w_rd = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (w_way_hit[w]) begin
                w_rd = w_rd | r_data[w][w_idx][{w_off, 5'd0} +: 32];
            end
        end
    end

    assign hit        = w_hit && !rst;
    assign ins        = hit ? w_rd : 32'd0;
    assign busy       = (r_state != c_IDLE) && !rst;
    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;
    assign miss_count = r_miss_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_fcnt       <= '0;
            r_flush_pend <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
            end
            r_lru        <= '0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_miss_count <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_hit) begin
                        // Way 0 used -> way 1 is next victim, and vice versa.
                        r_lru[w_idx] <= w_way_hit[0];
                    end
                    if (flush) begin
                        // A simultaneous miss is dropped; it re-misses later.
                        r_state <= c_FLUSH;
                        r_fcnt  <= '0;
                    end else if (cpu_req && !(|w_way_hit)) begin
                        r_mem_addr <= {cpu_addr[ADDR_W-1:c_OFF], {c_OFF{1'b0}}};
                        r_mem_req  <= 1'b1;
                        if (r_miss_count != 16'hFFFF) begin
                            r_miss_count <= r_miss_count + 16'd1;
                        end
                        r_state <= c_REFILL;
                    end
                end
                c_REFILL: begin
                    if (mem_valid) begin
                        r_valid[w_fidx] <= r_valid[w_fidx] | w_victim_oh;
                        r_lru[w_fidx]   <= w_victim_oh[0];
                        r_mem_req       <= 1'b0;
                        r_flush_pend    <= 1'b0;
                        r_fcnt          <= '0;
                        r_state         <= (r_flush_pend || flush) ? c_FLUSH : c_IDLE;
                    end else if (flush) begin
                        r_flush_pend <= 1'b1;
                    end
                end
                c_FLUSH: begin
                    r_valid[r_fcnt] <= '0;
                    r_lru[r_fcnt]   <= 1'b0;
                    r_fcnt          <= r_fcnt + 1'b1;
                    if (r_fcnt == c_IDX'(SETS - 1)) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Line storage carries no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (!rst && w_fill) begin
            for (int w = 0; w < WAYS; w++) begin
                if (w_victim_oh[w]) begin
                    r_data[w][w_fidx] <= mem_line;
                    r_tag[w][w_fidx]  <= w_ftag;
                end
            end
        end
    end

endmodule
`default_nettype wire
